// File: rtl/sdc_supervisor.sv
// sdc_supervisor: AS-side SDC close/open sequencer with watchdog kick, heartbeat supervision and sticky faults.
// Define SDC_SUP_WD_SELFTEST_EN to add the post-reset watchdog self-test (SELFTEST state, fault code 5).
module sdc_supervisor #(
  parameter int WD_HALF_PERIOD = 500,
  parameter int READY_TIMEOUT  = 10000,
  parameter int CLOSE_TIMEOUT  = 100000,
  parameter int OPEN_TIMEOUT   = 10000,
  parameter int HB_TIMEOUT     = 5000,
  parameter int CNT_W          = 17
) (
  input  logic       Clock,
  input  logic       Power_on_Reset,
  input  logic       Close_request,
  input  logic       Open_request,
  input  logic       Heartbeat,
  input  logic       SDC_is_Ready,
  input  logic       SDC_relais_fb,
  output logic       Watchdog_kick,
  output logic       AS_close_SDC,
  output logic       SDC_closed,
  output logic       Fault,
  output logic [2:0] Fault_code,
  output logic [2:0] State
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_CLOSING = 3'd2, S_CLOSED = 3'd3, S_OPEN = 3'd4, S_FAULT = 3'd5;
`ifdef SDC_SUP_WD_SELFTEST_EN
  localparam logic [2:0] S_SELFTEST = 3'd6;
  logic boot, st_phase;
`endif
  localparam logic [CNT_W-1:0] WD_LIM  = CNT_W'(WD_HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] RDY_LIM = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CLS_LIM = CNT_W'(CLOSE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OPN_LIM = CNT_W'(OPEN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HB_LIM  = CNT_W'(HB_TIMEOUT - 1);
  logic [2:0] state, nxt, nxt_code;
  logic [CNT_W-1:0] cnt, hb, wd;
  logic kick_en, hb_hold, hb_to, adv;
  assign State = state;
  // nxt_code is only consumed on the edge that enters FAULT, so each state sets its own code unconditionally
  always_comb begin
    nxt = state;
    nxt_code = 3'd0;
    adv = 1'b0;
    kick_en = state != S_OPEN && state != S_FAULT;
    hb_hold = state == S_IDLE;
`ifdef SDC_SUP_WD_SELFTEST_EN
    if (state == S_SELFTEST) begin
      hb_hold = 1'b1;
      kick_en = st_phase;
    end
`endif
    hb_to = !hb_hold && state != S_FAULT && !Heartbeat && hb >= HB_LIM;
    if (hb_to) begin
      nxt = S_FAULT;
      nxt_code = 3'd3;
    end else begin
      case (state)
        S_IDLE: begin
`ifdef SDC_SUP_WD_SELFTEST_EN
          if (boot) nxt = S_SELFTEST; else
`endif
          if (Close_request && !Open_request) nxt = S_WAIT;
        end
        S_WAIT: begin
          nxt_code = 3'd1;
          nxt = Open_request ? S_OPEN : SDC_is_Ready ? S_CLOSING : cnt >= RDY_LIM ? S_FAULT : !Close_request ? S_IDLE : S_WAIT;
        end
        S_CLOSING: nxt = Open_request ? S_OPEN : SDC_relais_fb ? S_CLOSED : (cnt >= CLS_LIM || !Close_request) ? S_IDLE : S_CLOSING;
        S_CLOSED: begin
          nxt_code = 3'd2;
          nxt = Open_request ? S_OPEN : !SDC_relais_fb ? S_FAULT : S_CLOSED;
        end
        S_OPEN: begin
          nxt_code = 3'd4;
          nxt = (!SDC_relais_fb && !SDC_is_Ready && !Open_request && !Close_request) ? S_IDLE : (SDC_relais_fb && cnt >= OPN_LIM) ? S_FAULT : S_OPEN;
        end
`ifdef SDC_SUP_WD_SELFTEST_EN
        S_SELFTEST: begin
          nxt_code = 3'd5;
          adv = !st_phase && !SDC_is_Ready;
          nxt = (st_phase && SDC_is_Ready) ? S_IDLE : (!adv && cnt >= RDY_LIM) ? S_FAULT : S_SELFTEST;
        end
`endif
        S_FAULT: nxt = S_FAULT;
        default: nxt = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge Clock) begin
    if (Power_on_Reset) begin
      state <= S_IDLE;
      cnt <= '0;
      hb <= '0;
      wd <= '0;
      Watchdog_kick <= 1'b0;
      AS_close_SDC <= 1'b0;
      SDC_closed <= 1'b0;
      Fault <= 1'b0;
      Fault_code <= 3'd0;
`ifdef SDC_SUP_WD_SELFTEST_EN
      boot <= 1'b1;
      st_phase <= 1'b0;
`endif
    end else begin
      state <= nxt;
      cnt <= (nxt != state || adv) ? '0 : &cnt ? cnt : cnt + 1'b1;
      hb <= (hb_hold || Heartbeat) ? '0 : &hb ? hb : hb + 1'b1;
      if (kick_en) begin
        wd <= wd >= WD_LIM ? '0 : wd + 1'b1;
        if (wd >= WD_LIM) Watchdog_kick <= !Watchdog_kick;
      end
      // rises one cycle after CLOSING entry, drops on the same edge that leaves CLOSING/CLOSED
      AS_close_SDC <= (state == S_CLOSING || state == S_CLOSED) && (nxt == S_CLOSING || nxt == S_CLOSED);
      SDC_closed <= nxt == S_CLOSED;
      Fault <= nxt == S_FAULT;
      if (nxt == S_FAULT && state != S_FAULT) Fault_code <= nxt_code;
`ifdef SDC_SUP_WD_SELFTEST_EN
      boot <= 1'b0;
      st_phase <= st_phase | adv;
`endif
    end
  end
endmodule

// File: tb/tb_sdc_supervisor.sv
// tb_sdc_supervisor: directed bench for sdc_supervisor with short timeouts.
module tb_sdc_supervisor;
  logic clk = 0, rst = 1, close_req = 0, open_req = 0, hb_man = 0, hb_auto = 0, hb_en = 1, ready = 0, fb = 0;
  logic kick, as_close, closed, fault, k0;
  logic [2:0] code, st;
  int pass = 0, total = 0, hb_div = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hb_en) begin
      hb_div = (hb_div == 9) ? 0 : hb_div + 1;
      hb_auto = hb_div == 0;
    end else hb_auto = 0;
  end

  sdc_supervisor #(.WD_HALF_PERIOD(4), .READY_TIMEOUT(20), .CLOSE_TIMEOUT(50), .OPEN_TIMEOUT(20), .HB_TIMEOUT(30), .CNT_W(17)) dut (
    .Clock(clk), .Power_on_Reset(rst), .Close_request(close_req), .Open_request(open_req),
    .Heartbeat(hb_auto | hb_man), .SDC_is_Ready(ready), .SDC_relais_fb(fb),
    .Watchdog_kick(kick), .AS_close_SDC(as_close), .SDC_closed(closed), .Fault(fault),
    .Fault_code(code), .State(st)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1; close_req = 0; open_req = 0; ready = 0; fb = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic go_closed;
    do_reset();
    close_req = 1; ready = 1; fb = 1;
    tick(3);
  endtask

  task automatic test_reset;
    tick(3);
    total++; if ({kick, as_close, closed, fault, code, st} !== 10'd0) $display("FAIL reset_outputs: got %b want 0", {kick, as_close, closed, fault, code, st}); else pass++;
    rst = 0;
    tick(3);
    total++; if (kick !== 1'b0) $display("FAIL kick_c3: got %b want 0", kick); else pass++;
    tick(1);
    total++; if (kick !== 1'b1) $display("FAIL kick_c4: got %b want 1", kick); else pass++;
    tick(4);
    total++; if (kick !== 1'b0) $display("FAIL kick_c8: got %b want 0", kick); else pass++;
    tick(4);
    total++; if (kick !== 1'b1) $display("FAIL kick_c12: got %b want 1", kick); else pass++;
    total++; if (st !== 3'd0) $display("FAIL idle_state: got %0d want 0", st); else pass++;
  endtask

  task automatic test_close;
    do_reset();
    close_req = 1;
    tick(1);
    total++; if (st !== 3'd1) $display("FAIL wait_entry: got %0d want 1", st); else pass++;
    tick(2);
    total++; if (st !== 3'd1) $display("FAIL wait_hold: got %0d want 1", st); else pass++;
    ready = 1;
    tick(1);
    total++; if ({st, as_close} !== {3'd2, 1'b0}) $display("FAIL closing_entry: got st=%0d as_close=%b want st=2 as_close=0", st, as_close); else pass++;
    tick(1);
    total++; if (as_close !== 1'b1) $display("FAIL closing_as_close: got %b want 1", as_close); else pass++;
    tick(4);
    fb = 1;
    tick(1);
    total++; if ({st, closed, as_close, fault} !== {3'd3, 1'b1, 1'b1, 1'b0}) $display("FAIL closed_entry: got st=%0d closed=%b as_close=%b fault=%b want 3 1 1 0", st, closed, as_close, fault); else pass++;
  endtask

  task automatic test_reset_mid;
    go_closed();
    total++; if (st !== 3'd3) $display("FAIL mid_closed: got %0d want 3", st); else pass++;
    rst = 1;
    tick(1);
    total++; if ({st, as_close, closed, fault} !== 6'd0) $display("FAIL mid_reset: got st=%0d as_close=%b closed=%b fault=%b want all 0", st, as_close, closed, fault); else pass++;
    rst = 0;
  endtask

  task automatic test_unexpected_open;
    go_closed();
    total++; if (st !== 3'd3) $display("FAIL uo_closed: got %0d want 3", st); else pass++;
    fb = 0;
    tick(1);
    total++; if ({st, fault, code, as_close, closed} !== {3'd5, 1'b1, 3'd2, 1'b0, 1'b0}) $display("FAIL uo_fault: got st=%0d fault=%b code=%0d as_close=%b closed=%b want 5 1 2 0 0", st, fault, code, as_close, closed); else pass++;
    k0 = kick;
    tick(10);
    total++; if (kick !== k0) $display("FAIL uo_kick_frozen: got %b want %b", kick, k0); else pass++;
    fb = 1; ready = 1;
    tick(3);
    total++; if ({st, fault, code} !== {3'd5, 1'b1, 3'd2}) $display("FAIL uo_sticky: got st=%0d fault=%b code=%0d want 5 1 2", st, fault, code); else pass++;
    do_reset();
    total++; if ({st, fault, code} !== 7'd0) $display("FAIL uo_cleared: got st=%0d fault=%b code=%0d want 0 0 0", st, fault, code); else pass++;
  endtask

  task automatic test_open;
    go_closed();
    open_req = 1;
    tick(1);
    total++; if ({st, as_close, closed} !== {3'd4, 1'b0, 1'b0}) $display("FAIL open_entry: got st=%0d as_close=%b closed=%b want 4 0 0", st, as_close, closed); else pass++;
    k0 = kick;
    tick(7);
    fb = 0; ready = 0;
    tick(3);
    total++; if ({st, kick} !== {3'd4, k0}) $display("FAIL open_hold: got st=%0d kick=%b want 4 %b", st, kick, k0); else pass++;
    open_req = 0; close_req = 0;
    tick(1);
    total++; if ({st, kick, fault} !== {3'd0, k0, 1'b0}) $display("FAIL open_exit: got st=%0d kick=%b fault=%b want 0 %b 0", st, kick, fault, k0); else pass++;
    tick(4);
    total++; if (kick !== !k0) $display("FAIL kick_resume: got %b want %b", kick, !k0); else pass++;
    go_closed();
    open_req = 1;
    tick(1);
    tick(19);
    total++; if (st !== 3'd4) $display("FAIL open_before_to: got %0d want 4", st); else pass++;
    tick(1);
    total++; if ({st, fault, code, as_close} !== {3'd5, 1'b1, 3'd4, 1'b0}) $display("FAIL open_timeout: got st=%0d fault=%b code=%0d as_close=%b want 5 1 4 0", st, fault, code, as_close); else pass++;
    open_req = 0;
  endtask

  task automatic test_heartbeat;
    go_closed();
    hb_en = 0;
    tick(2);
    hb_man = 1;
    tick(1);
    hb_man = 0;
    tick(29);
    total++; if (st !== 3'd3) $display("FAIL hb_before_to: got %0d want 3", st); else pass++;
    open_req = 1;
    tick(1);
    total++; if ({st, fault, code} !== {3'd5, 1'b1, 3'd3}) $display("FAIL hb_timeout: got st=%0d fault=%b code=%0d want 5 1 3", st, fault, code); else pass++;
    open_req = 0;
    hb_en = 1;
  endtask

  task automatic test_timeouts;
    do_reset();
    close_req = 1;
    tick(1);
    tick(19);
    total++; if (st !== 3'd1) $display("FAIL ready_before_to: got %0d want 1", st); else pass++;
    tick(1);
    total++; if ({st, fault, code} !== {3'd5, 1'b1, 3'd1}) $display("FAIL ready_timeout: got st=%0d fault=%b code=%0d want 5 1 1", st, fault, code); else pass++;
    do_reset();
    close_req = 1; ready = 1;
    tick(2);
    total++; if (st !== 3'd2) $display("FAIL close_entry: got %0d want 2", st); else pass++;
    tick(49);
    total++; if ({st, as_close} !== {3'd2, 1'b1}) $display("FAIL close_before_to: got st=%0d as_close=%b want 2 1", st, as_close); else pass++;
    tick(1);
    total++; if ({st, fault, as_close} !== {3'd0, 1'b0, 1'b0}) $display("FAIL close_timeout: got st=%0d fault=%b as_close=%b want 0 0 0", st, fault, as_close); else pass++;
    close_req = 0; ready = 0;
  endtask

  initial begin
    test_reset();
    test_close();
    test_reset_mid();
    test_unexpected_open();
    test_open();
    test_heartbeat();
    test_timeouts();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
